// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : imem_dmem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               icache refill port and the data port, with a per-grant beat cap.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_valid,
    output logic                  grant_i,
    output logic                  grant_d
);

    localparam int                CNT_W       = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_next_beat_cnt;
    logic               r_last_gnt;
    logic               w_next_last_gnt;
    logic               w_owner_req;
    logic               w_other_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_last_gnt <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_beat_cnt <= w_next_beat_cnt;
            r_last_gnt <= w_next_last_gnt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_beat_cnt = r_beat_cnt;
        w_next_last_gnt = r_last_gnt;
        w_owner_req     = 1'b0;
        w_other_req     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_beat_cnt = '0;
                // last_gnt == 0 means I went last, so D wins a tie
                if (i_req && d_req) begin
                    w_next_state = r_last_gnt ? GNT_I : GNT_D;
                end else if (i_req) begin
                    w_next_state = GNT_I;
                end else if (d_req) begin
                    w_next_state = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                w_owner_req = (r_state == GNT_I) ? i_req : d_req;
                w_other_req = (r_state == GNT_I) ? d_req : i_req;
                if (w_owner_req && m_valid) begin
                    w_next_beat_cnt = r_beat_cnt + 1'b1;
                end
                if (!w_owner_req || (m_valid && (r_beat_cnt == C_LAST_BEAT))) begin
                    w_next_last_gnt = (r_state == GNT_D);
                    w_next_beat_cnt = '0;
                    if (w_other_req) begin
                        w_next_state = (r_state == GNT_I) ? GNT_D : GNT_I;
                    end else if (w_owner_req) begin
                        w_next_state = r_state;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_next_beat_cnt = '0;
            end
        endcase
    end

    // Valids are qualified by the owner's req so stray beats are dropped
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        i_data  = '0;
        i_valid = 1'b0;
        d_rdata = '0;
        d_valid = 1'b0;
        case (r_state)
            GNT_I: begin
                grant_i = 1'b1;
                m_req   = i_req;
                m_addr  = i_addr;
                i_data  = m_rdata;
                i_valid = m_valid & i_req;
            end
            GNT_D: begin
                grant_d = 1'b1;
                m_req   = d_req;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                d_rdata = m_rdata;
                d_valid = m_valid & d_req;
            end
            default: begin
                grant_i = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imem_dmem_port_arbiter
// Description : Vector table, reset corner sequence and randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

    localparam int MAX_BEATS = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] IA = 32'h100;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic        grant_i;
    logic        grant_d;

    int n_cmp;
    int n_err;

    imem_dmem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_valid (i_valid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_valid (m_valid),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mr;
        logic        mv;
        logic        gi;
        logic        gd;
        logic        mq;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        iv;
        logic [31:0] id;
        logic        dv;
        logic [31:0] dd;
    } vec_t;

    vec_t vecs [25];

    function automatic logic [133:0] pk(input logic gi, input logic gd, input logic mq,
                                        input logic mw, input logic [31:0] ma,
                                        input logic [31:0] mwd, input logic iv,
                                        input logic [31:0] id, input logic dv,
                                        input logic [31:0] dd);
        return {gi, gd, mq, mw, ma, mwd, iv, id, dv, dd};
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [31:0] mr, input logic mv);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        m_rdata = mr;
        m_valid = mv;
    endtask

    task automatic check(input string name, input logic [133:0] exp);
        logic [133:0] got;
        got = pk(grant_i, grant_d, m_req, m_we, m_addr, m_wdata,
                 i_valid, i_data, d_valid, d_rdata);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: who owns the port, beats delivered in this grant,
    // and whether D was the most recent owner.
    int owner;
    int beats;
    bit last_d;

    function automatic logic [133:0] model_out();
        if (owner == 1)
            return pk(T, F, i_req, F, i_addr, Z, m_valid & i_req, m_rdata, F, Z);
        else if (owner == 2)
            return pk(F, T, d_req, d_we, d_addr, d_wdata, F, Z, m_valid & d_req, m_rdata);
        return '0;
    endfunction

    task automatic model_step();
        bit own_req;
        bit oth_req;
        bit done;
        if (owner == 0) begin
            beats = 0;
            if (i_req && d_req) owner = last_d ? 1 : 2;
            else if (i_req)     owner = 1;
            else if (d_req)     owner = 2;
        end else begin
            own_req = (owner == 1) ? i_req : d_req;
            oth_req = (owner == 1) ? d_req : i_req;
            done    = m_valid && (beats + 1 == MAX_BEATS);
            if (own_req && m_valid) beats = beats + 1;
            if (!own_req || done) begin
                last_d = (owner == 2);
                beats  = 0;
                if (oth_req)      owner = 3 - owner;
                else if (!own_req) owner = 0;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(T, IA, T, T, 32'h2000, DB, 32'h1234, T);

        vecs[0]  = '{T, IA, F, F, Z, Z, Z, F,                       F, F, F, F, Z, Z, F, Z, F, Z};
        vecs[1]  = '{T, IA, F, F, Z, Z, 32'hA0, T,                  T, F, T, F, IA, Z, T, 32'hA0, F, Z};
        vecs[2]  = '{T, IA, F, F, Z, Z, 32'hA1, T,                  T, F, T, F, IA, Z, T, 32'hA1, F, Z};
        vecs[3]  = '{T, IA, F, F, Z, Z, 32'hA2, T,                  T, F, T, F, IA, Z, T, 32'hA2, F, Z};
        vecs[4]  = '{T, IA, F, F, Z, Z, 32'hA3, T,                  T, F, T, F, IA, Z, T, 32'hA3, F, Z};
        vecs[5]  = '{F, IA, F, F, Z, Z, Z, F,                       T, F, F, F, IA, Z, F, Z, F, Z};
        vecs[6]  = '{F, Z, F, F, Z, Z, Z, F,                        F, F, F, F, Z, Z, F, Z, F, Z};
        vecs[7]  = '{T, IA, T, T, 32'h2000, DB, Z, F,               F, F, F, F, Z, Z, F, Z, F, Z};
        vecs[8]  = '{T, IA, T, T, 32'h2000, DB, Z, T,               F, T, T, T, 32'h2000, DB, F, Z, T, Z};
        vecs[9]  = '{T, IA, F, T, 32'h2000, DB, Z, F,               F, T, F, T, 32'h2000, DB, F, Z, F, Z};
        vecs[10] = '{T, IA, F, F, Z, Z, 32'hA0, T,                  T, F, T, F, IA, Z, T, 32'hA0, F, Z};
        vecs[11] = '{T, IA, T, F, 32'h3000, Z, 32'hA1, T,           T, F, T, F, IA, Z, T, 32'hA1, F, Z};
        vecs[12] = '{T, IA, T, F, 32'h3000, Z, 32'hA2, T,           T, F, T, F, IA, Z, T, 32'hA2, F, Z};
        vecs[13] = '{T, IA, T, F, 32'h3000, Z, 32'hA3, T,           T, F, T, F, IA, Z, T, 32'hA3, F, Z};
        vecs[14] = '{T, IA, T, F, 32'h3000, Z, 32'h55, T,           F, T, T, F, 32'h3000, Z, F, Z, T, 32'h55};
        vecs[15] = '{T, IA, F, F, 32'h3000, Z, Z, F,                F, T, F, F, 32'h3000, Z, F, Z, F, Z};
        vecs[16] = '{T, IA, F, F, Z, Z, 32'hB0, T,                  T, F, T, F, IA, Z, T, 32'hB0, F, Z};
        vecs[17] = '{T, IA, F, F, Z, Z, 32'hB1, T,                  T, F, T, F, IA, Z, T, 32'hB1, F, Z};
        vecs[18] = '{T, IA, F, F, Z, Z, 32'hB2, T,                  T, F, T, F, IA, Z, T, 32'hB2, F, Z};
        vecs[19] = '{T, IA, T, F, 32'h4000, Z, 32'hB3, T,           T, F, T, F, IA, Z, T, 32'hB3, F, Z};
        vecs[20] = '{F, Z, T, F, 32'h4000, Z, Z, F,                 F, T, T, F, 32'h4000, Z, F, Z, F, Z};
        vecs[21] = '{F, Z, T, F, 32'h4000, Z, 32'h77, T,            F, T, T, F, 32'h4000, Z, F, Z, T, 32'h77};
        vecs[22] = '{F, Z, F, F, 32'h4000, Z, Z, F,                 F, T, F, F, 32'h4000, Z, F, Z, F, Z};
        vecs[23] = '{F, Z, F, F, Z, Z, 32'h99, T,                   F, F, F, F, Z, Z, F, Z, F, Z};
        vecs[24] = '{F, Z, F, F, Z, Z, Z, F,                        F, F, F, F, Z, Z, F, Z, F, Z};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", '0);
        rst = 1'b0;

        for (int k = 0; k < 25; k++) begin
            drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw,
                  vecs[k].da, vecs[k].dwd, vecs[k].mr, vecs[k].mv);
            #1;
            check($sformatf("vec%0d", k),
                  pk(vecs[k].gi, vecs[k].gd, vecs[k].mq, vecs[k].mw, vecs[k].ma,
                     vecs[k].mwd, vecs[k].iv, vecs[k].id, vecs[k].dv, vecs[k].dd));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a refill
        drive(T, 32'h500, F, F, Z, Z, Z, F);
        #1 check("rst_seq_idle", '0);
        @(negedge clk);
        drive(T, 32'h500, F, F, Z, Z, 32'hC0, T);
        #1 check("rst_seq_beat1", pk(T, F, T, F, 32'h500, Z, T, 32'hC0, F, Z));
        @(negedge clk);
        drive(T, 32'h500, F, F, Z, Z, 32'hC1, T);
        #1 check("rst_seq_beat2", pk(T, F, T, F, 32'h500, Z, T, 32'hC1, F, Z));
        #2 rst = 1'b1;
        #1 check("rst_seq_async_drop", '0);
        @(negedge clk);
        rst = 1'b0;
        drive(T, 32'h500, T, F, 32'h600, Z, Z, F);
        #1 check("rst_seq_after_idle", '0);
        @(negedge clk);
        #1 check("rst_seq_prefer_d", pk(F, T, T, F, 32'h600, Z, F, Z, F, Z));
        @(negedge clk);

        // Randomized run against the reference model
        rst = 1'b1;
        drive(F, Z, F, F, Z, Z, Z, F);
        @(negedge clk);
        rst    = 1'b0;
        owner  = 0;
        beats  = 0;
        last_d = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) i_req = ~i_req;
            if ($urandom_range(3) == 0) d_req = ~d_req;
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(1));
            m_rdata = $urandom;
            m_valid = ($urandom_range(2) != 0);
            #1;
            check($sformatf("rand_cycle%0d", c), model_out());
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported memory interface between the instruction-cache refill port and the data port (data cache or uncached load/store unit).
- Sits between both requesters and the memory/bus adapter.
- Grants whole refill bursts atomically.
- Arbitrates round-robin between the two requesters, with a beat cap so neither requester can starve the other.

Parameters:
- ADDR_WIDTH, 32, address width for all ports.
- DATA_WIDTH, 32, data width for all ports.
- MAX_BEATS, 4, maximum m_valid beats per grant before forced re-arbitration; must be ≥1. Set equal to the icache line words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  1  instruction requester request; held high for the whole refill.
- i_addr  input  ADDR_WIDTH  instruction word address.
- i_data  output  DATA_WIDTH  read data to the instruction requester.
- i_valid  output  1  read beat valid to the instruction requester.
- d_req  input  1  data requester request; held until its d_valid.
- d_we  input  1  data write enable.
- d_addr  input  ADDR_WIDTH  data address.
- d_wdata  input  DATA_WIDTH  data write data.
- d_rdata  output  DATA_WIDTH  read data to the data requester.
- d_valid  output  1  read-data valid or write acknowledge to the data requester.
- m_req  output  1  memory request.
- m_we  output  1  memory write enable.
- m_addr  output  ADDR_WIDTH  memory address.
- m_wdata  output  DATA_WIDTH  memory write data.
- m_rdata  input  DATA_WIDTH  memory read data.
- m_valid  input  1  memory beat done (read data valid or write ack).
- grant_i  output  1  instruction requester currently owns memory.
- grant_d  output  1  data requester currently owns memory.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Registers: state, beat_cnt (clog2(MAX_BEATS+1) bits), last_gnt (0 = I, 1 = D).
- Reset (asynchronous): state=IDLE, beat_cnt=0, last_gnt=0, so D is preferred first.
  - All outputs are combinational from state and are 0 while in reset or IDLE. This covers m_req, m_we, m_addr, m_wdata, i_data, i_valid, d_rdata, d_valid, grant_i, grant_d.
- IDLE:
  - Only i_req → GNT_I.
  - Only d_req → GNT_D.
  - Both → the one not equal to last_gnt.
  - beat_cnt cleared.
  - Arbitration latency is one cycle: no memory request is issued in the cycle a request first appears.
- GNT_I:
  - grant_i=1.
  - m_req=i_req, m_addr=i_addr, m_we=0, m_wdata=0.
  - i_data=m_rdata and i_valid=m_valid.
  - d_valid=0, d_rdata=0.
- GNT_D:
  - grant_d=1.
  - m_req=d_req, m_we=d_we, m_addr=d_addr, m_wdata=d_wdata.
  - d_rdata=m_rdata and d_valid=m_valid.
  - i_valid=0, i_data=0.
- Beat counting: beat_cnt increments on each m_valid while granted.
- Release condition (evaluated each cycle in a GNT state):
  - the owner's req is low, or
  - m_valid is high and beat_cnt==MAX_BEATS-1.
  - On release: last_gnt=owner, beat_cnt=0.
  - Next state on release:
    - GNT_other if the other req is high (no IDLE bubble);
    - else GNT_same if the owner's req is still high (forced release only);
    - else IDLE.
- Owner req low on grant entry: the grant is released in that same cycle, with no memory request issued.
- m_valid in IDLE, or while the owner's req is low, is discarded: no valid is routed to either requester.
- A non-owner requester sees no response; it simply waits with req held.
- Requesters must not change addr/we/wdata while req is high and they are not yet acknowledged. This is not checked.
- Reset mid-burst:
  - m_req, the grants and the valids drop to 0 asynchronously.
  - The partial burst is abandoned; the requesters re-issue after reset.

Test Plan:
- Reset, then i_req=1 alone at i_addr=0x100, memory returns 4 beats 0xA0..0xA3 → grant_i one cycle after the request; i_valid/i_data mirror the 4 beats; d_valid stays 0 throughout; release after the 4th beat; state IDLE once i_req drops.
- i_req and d_req rise in the same cycle after reset → grant_d first (last_gnt=0). After the d write (d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF) is acked, grant_i follows the next cycle with no IDLE bubble; m_we=1 only during GNT_D.
- d_req asserted during beat 2 of an icache refill → grant_i held until the 4th beat completes; grant_d the cycle after; m_addr switches to d_addr only then.
- MAX_BEATS=4 with i_req held for 8 beats and d_req pending → after beat 4, grant_d. After d_valid, grant_i is re-granted and beat_cnt restarts at 0.
- rst pulsed mid-refill after beat 1 → m_req, grant_i and i_valid go to 0 immediately without waiting for a clock. After release, an i_req with d_req pending grants D first.
- m_valid pulsed in IDLE with no requests → i_valid=d_valid=0; state stays IDLE.
